// File: rtl/dff_chk_pkg.sv
// Shared types and defaults for the dff response checker.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } chk_state_e;

    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != MAX)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dff_response_checker.sv
// Compares a dff DUT against a one-cycle reference flop and tracks
// sample / data-mismatch / complement-error counts plus error flags.
module dff_response_checker
    import dff_chk_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             dut_rstn,
    input  logic             d,
    input  logic             y,
    input  logic             ybar,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] samples,
    output logic [CNT_W-1:0] mismatches,
    output logic [CNT_W-1:0] comp_errs,
    output logic [1:0]       state
);

    chk_state_e state_q, state_d;
    logic       exp_q, exp_d;
    logic       err_pulse_q, err_pulse_d;
    logic       err_sticky_q, err_sticky_d;

    logic       y_exp_c;
    logic       mis_c;
    logic       comp_c;
    logic       err_c;
    logic       cnt_en_c;
    logic       inc_samples_c;
    logic       inc_mis_c;
    logic       inc_comp_c;

    always_comb begin
        state_d       = state_q;
        exp_d         = dut_rstn ? d : 1'b0;
        // The DUT's async reset is already visible on y at the sampling edge.
        y_exp_c       = dut_rstn ? exp_q : 1'b0;
        mis_c         = (y != y_exp_c);
        comp_c        = (ybar == y);
        err_c         = (state_q == CHECK) && (mis_c || comp_c);
        cnt_en_c      = (state_q == CHECK) && en;
        inc_samples_c = cnt_en_c;
        inc_mis_c     = cnt_en_c && mis_c;
        inc_comp_c    = cnt_en_c && comp_c;
        err_pulse_d   = err_c;
        err_sticky_d  = err_sticky_q | (err_c && en);

        case (state_q)
            IDLE:    if (en) state_d = PRIME;
            PRIME:   state_d = CHECK;
            CHECK: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (STOP_ON_ERR && err_c) begin
                    state_d = HALT;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d      = IDLE;
            err_pulse_d  = 1'b0;
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_q        <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_samples (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (inc_samples_c),
        .q   (samples)
    );

    sat_counter #(.W(CNT_W)) u_mismatches (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (inc_mis_c),
        .q   (mismatches)
    );

    sat_counter #(.W(CNT_W)) u_comp_errs (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (inc_comp_c),
        .q   (comp_errs)
    );

    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign state      = state_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker: a 16-bit free-running instance
// and a 2-bit stop-on-error instance share the same stimulus.
module tb_dff_response_checker;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clear;
    logic        dut_rstn;
    logic        d;
    logic        y;
    logic        ybar;

    logic        a_pulse, a_sticky;
    logic [15:0] a_samples, a_mis, a_comp;
    logic [1:0]  a_state;

    logic        s_pulse, s_sticky;
    logic [1:0]  s_samples, s_mis, s_comp;
    logic [1:0]  s_state;

    logic        yq;
    int          n_vec;
    int          n_miss;

    dff_response_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .dut_rstn   (dut_rstn),
        .d          (d),
        .y          (y),
        .ybar       (ybar),
        .err_pulse  (a_pulse),
        .err_sticky (a_sticky),
        .samples    (a_samples),
        .mismatches (a_mis),
        .comp_errs  (a_comp),
        .state      (a_state)
    );

    dff_response_checker #(.CNT_W(2), .STOP_ON_ERR(1'b1)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .dut_rstn   (dut_rstn),
        .d          (d),
        .y          (y),
        .ybar       (ybar),
        .err_pulse  (s_pulse),
        .err_sticky (s_sticky),
        .samples    (s_samples),
        .mismatches (s_mis),
        .comp_errs  (s_comp),
        .state      (s_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one edge's worth of inputs; yq tracks what a correct dff would show next.
    task automatic step_raw(input logic dv, input logic rv, input logic yv, input logic ybv);
        d        = dv;
        dut_rstn = rv;
        y        = yv;
        ybar     = ybv;
        tick();
        yq = rv ? dv : 1'b0;
    endtask

    task automatic step(input logic dv);
        step_raw(dv, 1'b1, yq, ~yq);
    endtask

    // Wrong y but still complementary ybar.
    task automatic fault();
        step_raw(1'b0, 1'b1, ~yq, yq);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        clear    = 1'b0;
        dut_rstn = 1'b0;
        d        = 1'b0;
        y        = 1'b0;
        ybar     = 1'b1;
        yq       = 1'b0;
        tick();
        tick();
        check_eq("rst_state",   32'(a_state),   32'd0);
        check_eq("rst_samples", 32'(a_samples), 32'd0);
        check_eq("rst_pulse",   32'(a_pulse),   32'd0);
        check_eq("rst_sticky",  32'(a_sticky),  32'd0);

        rst      = 1'b0;
        dut_rstn = 1'b1;

        // Golden run: enable, prime, then four clean compares with d=1,0,1,1.
        en = 1'b1;
        step(1'b0);
        check_eq("prime_state", 32'(a_state), 32'd1);
        step(1'b0);
        check_eq("check_state", 32'(a_state), 32'd2);
        check_eq("no_cmp_yet",  32'(a_samples), 32'd0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check_eq("gold_samples", 32'(a_samples), 32'd4);
        check_eq("gold_mis",     32'(a_mis),     32'd0);
        check_eq("gold_comp",    32'(a_comp),    32'd0);
        check_eq("gold_sticky",  32'(a_sticky),  32'd0);
        check_eq("gold_pulse",   32'(a_pulse),   32'd0);

        // Stuck-at-1 on y with ybar still complementary.
        step(1'b0);
        step_raw(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("stuck_mis",    32'(a_mis),     32'd1);
        check_eq("stuck_comp",   32'(a_comp),    32'd0);
        check_eq("stuck_pulse",  32'(a_pulse),   32'd1);
        check_eq("stuck_sticky", 32'(a_sticky),  32'd1);
        check_eq("stuck_samp",   32'(a_samples), 32'd6);
        step(1'b0);
        check_eq("pulse_drop",   32'(a_pulse),   32'd0);
        check_eq("sticky_hold",  32'(a_sticky),  32'd1);

        // y=ybar=1 while the DUT is held in reset: both counters bump together.
        step_raw(1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("rstn_mis",   32'(a_mis),     32'd2);
        check_eq("rstn_comp",  32'(a_comp),    32'd1);
        check_eq("rstn_pulse", 32'(a_pulse),   32'd1);
        check_eq("rstn_samp",  32'(a_samples), 32'd8);
        step(1'b0);
        check_eq("post_rstn_samp", 32'(a_samples), 32'd9);

        // Disable mid-run, then garbage on d/y/ybar must not be counted.
        en = 1'b0;
        step(1'b1);
        check_eq("dis_state", 32'(a_state),   32'd0);
        check_eq("dis_samp",  32'(a_samples), 32'd9);
        for (int i = 0; i < 5; i++) begin
            step_raw(1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
            check_eq("dis_rand_samp", 32'(a_samples), 32'd9);
            check_eq("dis_rand_mis",  32'(a_mis),     32'd2);
            check_eq("dis_rand_comp", 32'(a_comp),    32'd1);
        end
        en = 1'b1;
        step(1'b1);
        check_eq("reen_prime", 32'(a_state), 32'd1);
        step(1'b0);
        check_eq("reen_check", 32'(a_state), 32'd2);
        step(1'b1);
        check_eq("reen_samp", 32'(a_samples), 32'd10);
        fault();
        check_eq("reen_mis",   32'(a_mis),     32'd3);
        check_eq("reen_comp",  32'(a_comp),    32'd1);
        check_eq("reen_samp2", 32'(a_samples), 32'd11);
        check_eq("reen_pulse", 32'(a_pulse),   32'd1);

        // Async reset mid-cycle takes effect without a clock edge.
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_pulse",  32'(a_pulse),   32'd0);
        check_eq("async_sticky", 32'(a_sticky),  32'd0);
        check_eq("async_samp",   32'(a_samples), 32'd0);
        check_eq("async_mis",    32'(a_mis),     32'd0);
        check_eq("async_comp",   32'(a_comp),    32'd0);
        check_eq("async_state",  32'(a_state),   32'd0);
        #1;
        rst = 1'b0;
        yq  = 1'b0;

        // 2-bit saturation, stop-on-error halt, clear racing an error.
        step(1'b0);
        step(1'b0);
        check_eq("sat_check", 32'(s_state), 32'd2);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        check_eq("sat_samp3", 32'(s_samples), 32'd3);
        step(1'b0);
        step(1'b1);
        check_eq("sat_hold",  32'(s_samples), 32'd3);
        check_eq("sat_wide",  32'(a_samples), 32'd5);
        check_eq("sat_mis0",  32'(s_mis),     32'd0);
        fault();
        check_eq("halt_state", 32'(s_state),  32'd3);
        check_eq("halt_mis",   32'(s_mis),    32'd1);
        check_eq("halt_pulse", 32'(s_pulse),  32'd1);
        check_eq("halt_stky",  32'(s_sticky), 32'd1);
        fault();
        check_eq("frozen_mis",   32'(s_mis),   32'd1);
        check_eq("frozen_state", 32'(s_state), 32'd3);
        check_eq("frozen_pulse", 32'(s_pulse), 32'd0);
        check_eq("free_mis",     32'(a_mis),   32'd2);
        clear = 1'b1;
        fault();
        clear = 1'b0;
        check_eq("clr_samp",   32'(s_samples), 32'd0);
        check_eq("clr_mis",    32'(s_mis),     32'd0);
        check_eq("clr_sticky", 32'(s_sticky),  32'd0);
        check_eq("clr_pulse",  32'(s_pulse),   32'd0);
        check_eq("clr_state",  32'(s_state),   32'd0);
        check_eq("clr_a_mis",  32'(a_mis),     32'd0);
        step(1'b0);
        check_eq("clr_reprime", 32'(s_state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
